// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch/execute sequencer: fetches an opcode plus operand bytes, owns the PC, and drives the execute handshake.
// Optional read-wait timeout into a sticky fault state is compiled in when FETCH_TIMEOUT_EN is defined.
module instr_fetch_sequencer #(
    parameter int unsigned           ADDR_WIDTH   = 16,
    parameter int unsigned           DATA_WIDTH   = 8,
    parameter int unsigned           MAX_OPERANDS = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'('hF000),
    parameter logic [DATA_WIDTH-1:0] HLT_OPCODE   = DATA_WIDTH'('h01),
    parameter int unsigned           TIMEOUT_CYC  = 15
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic                               mem_read,
    input  logic [DATA_WIDTH-1:0]              mem_rdata,
    input  logic                               mem_rvalid,
    input  logic [$clog2(MAX_OPERANDS+1)-1:0]  op_len,
    output logic [DATA_WIDTH-1:0]              opcode,
    output logic [MAX_OPERANDS*DATA_WIDTH-1:0] operands,
    output logic                               exec_start,
    input  logic                               exec_done,
    input  logic                               pc_load,
    input  logic [ADDR_WIDTH-1:0]              pc_load_addr,
    output logic [ADDR_WIDTH-1:0]              pc,
    output logic                               halt,
    output logic                               fault
);
    localparam int unsigned      LEN_W   = $clog2(MAX_OPERANDS+1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_OPERANDS);

    typedef enum logic [2:0] {
        S_FETCH_OP,
        S_DECODE,
        S_FETCH_OPR,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    state_t state, next_state;

    logic [MAX_OPERANDS-1:0][DATA_WIDTH-1:0] opr;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] len_sat;
    logic             fetching;
    logic             accept;
    logic             enter_exec;
    logic             timeout;

    // Read request is gated by reset so nothing is requested while held in reset.
    assign fetching   = (state == S_FETCH_OP) || (state == S_FETCH_OPR);
    assign mem_read   = fetching && reset;
    assign mem_addr   = pc;
    assign accept     = mem_read && mem_rvalid;
    assign len_sat    = (op_len > LEN_MAX) ? LEN_MAX : op_len;
    assign operands   = opr;
    assign halt       = (state == S_HALT);
    assign enter_exec = (next_state == S_EXEC) && (state != S_EXEC);

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned WAIT_W = ($clog2(TIMEOUT_CYC+1) > 4) ? $clog2(TIMEOUT_CYC+1) : 4;

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (mem_read && !mem_rvalid) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout = mem_read && !mem_rvalid && (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
    assign fault   = (state == S_FAULT);
`else
    assign timeout = 1'b0;
    assign fault   = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH_OP: begin
                if (timeout) begin
                    next_state = S_FAULT;
                end else if (accept) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == HLT_OPCODE) begin
                    next_state = S_HALT;
                end else if (len_sat == '0) begin
                    next_state = S_EXEC;
                end else begin
                    next_state = S_FETCH_OPR;
                end
            end
            S_FETCH_OPR: begin
                if (timeout) begin
                    next_state = S_FAULT;
                end else if (accept && (cnt == LEN_W'(1))) begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    next_state = S_FETCH_OP;
                end
            end
            S_HALT:  next_state = S_HALT;
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_FETCH_OP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH_OP;
            pc         <= RESET_VECTOR;
            opcode     <= '0;
            opr        <= '0;
            cnt        <= '0;
            idx        <= '0;
            exec_start <= 1'b0;
        end else begin
            state      <= next_state;
            exec_start <= enter_exec;
            case (state)
                S_FETCH_OP: begin
                    if (accept) begin
                        opcode <= mem_rdata;
                        opr    <= '0;
                        pc     <= pc + ADDR_WIDTH'(1);
                    end
                end
                S_DECODE: begin
                    cnt <= len_sat;
                    idx <= '0;
                end
                S_FETCH_OPR: begin
                    if (accept) begin
                        for (int unsigned i = 0; i < MAX_OPERANDS; i++) begin
                            if (idx == LEN_W'(i)) begin
                                opr[i] <= mem_rdata;
                            end
                        end
                        pc  <= pc + ADDR_WIDTH'(1);
                        idx <= idx + LEN_W'(1);
                        cnt <= cnt - LEN_W'(1);
                    end
                end
                S_EXEC: begin
                    if (exec_done && pc_load) begin
                        pc <= pc_load_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Scoreboard bench for instr_fetch_sequencer: ROM responder with programmable wait, auto executor, exec_start monitor.
module tb_instr_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_read;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic [1:0]  op_len;
    logic [7:0]  opcode;
    logic [15:0] operands;
    logic        exec_start;
    logic        exec_done;
    logic        pc_load;
    logic [15:0] pc_load_addr;
    logic [15:0] pc;
    logic        halt;
    logic        fault;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] opr;
        logic [15:0] pc;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  rom [logic [15:0]];
    int          checks   = 0;
    int          errors   = 0;
    int          n_pushed = 0;
    int          n_pulses = 0;
    int          rd_wait  = 0;
    int          exec_lat = 0;
    bit          mem_en   = 1'b0;
    int          wc       = 0;
    int          ecnt     = 0;

    instr_fetch_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .op_len       (op_len),
        .opcode       (opcode),
        .operands     (operands),
        .exec_start   (exec_start),
        .exec_done    (exec_done),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .pc           (pc),
        .halt         (halt),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder stand-in: 3F asks for more operands than the sequencer supports.
    always_comb begin
        case (opcode)
            8'h3A:   op_len = 2'd2;
            8'h3B:   op_len = 2'd1;
            8'h3F:   op_len = 2'd3;
            default: op_len = 2'd0;
        endcase
    end

    function automatic logic [7:0] rom_rd(input logic [15:0] a);
        if (rom.exists(a)) return rom[a];
        return 8'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] op, input logic [15:0] opr, input logic [15:0] p);
        exp_t e;
        e.op  = op;
        e.opr = opr;
        e.pc  = p;
        q.push_back(e);
        n_pushed++;
    endtask

    // Memory responder: rd_wait idle cycles per byte, then rvalid until accepted.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_read || !mem_en) begin
                mem_rvalid = 1'b0;
                wc = 0;
            end else begin
                if (mem_rvalid) wc = 0;
                if (wc >= rd_wait) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rom_rd(mem_addr);
                end else begin
                    mem_rvalid = 1'b0;
                    wc++;
                end
            end
        end
    end

    // Executor: exec_done exec_lat cycles after exec_start (0 = same cycle).
    initial begin
        exec_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exec_done) begin
                exec_done = 1'b0;
            end else if (exec_start) begin
                if (exec_lat == 0) exec_done = 1'b1;
                else ecnt = exec_lat;
            end else if (ecnt > 0) begin
                ecnt--;
                if (ecnt == 0) exec_done = 1'b1;
            end
        end
    end

    // Monitor: every exec_start pulse must match the oldest expected instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exec_start === 1'b1) begin
                n_pulses++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_exec_start actual=%0h required=none", opcode);
                end else begin
                    e = q.pop_front();
                    chk("exec_opcode", {24'h0, opcode}, {24'h0, e.op});
                    chk("exec_operands", {16'h0, operands}, {16'h0, e.opr});
                    chk("exec_pc", {16'h0, pc}, {16'h0, e.pc});
                end
            end
        end
    end

    task automatic do_reset(input bit check_state);
        @(negedge clk);
        reset  = 1'b0;
        mem_en = 1'b0;
        repeat (2) @(negedge clk);
        if (check_state) begin
            chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
            chk("rst_pc", {16'h0, pc}, 32'h0000F000);
            chk("rst_opcode_operands", {8'h0, opcode, operands}, 32'h0);
            chk("rst_flags", {29'h0, exec_start, halt, fault}, 32'h0);
        end
        q.delete();
        rom.delete();
        n_pushed = 0;
        n_pulses = 0;
    endtask

    task automatic wait_exec(input string name, input int budget);
        int n = 0;
        while (exec_start !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'h0, exec_start}, 32'h1);
    endtask

    task automatic end_prog(input string name, input logic [15:0] pc_exp, input int budget);
        int n = 0;
        while (halt !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_halt"}, {31'h0, halt}, 32'h1);
        chk({name, "_pc_halt"}, {16'h0, pc}, {16'h0, pc_exp});
        chk({name, "_pending"}, q.size(), 32'h0);
        chk({name, "_pulses"}, n_pulses, n_pushed);
    endtask

    initial begin : main
        int n;
        reset        = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = 16'h0000;

        // HLT at the reset vector
        do_reset(1'b1);
        rom[16'hF000] = 8'h01;
        rd_wait = 0;
        mem_en  = 1'b1;
        reset   = 1'b1;
        @(negedge clk);
        chk("t1_read_cycle1", {15'h0, mem_read, mem_addr}, {16'h1, 16'hF000});
        @(negedge clk);
        chk("t1_decode", {7'h0, mem_read, opcode, pc}, {8'h0, 8'h01, 16'hF001});
        @(negedge clk);
        chk("t1_halt", {31'h0, halt}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t1_hold", {14'h0, halt, mem_read, pc}, {14'h0, 2'b10, 16'hF001});
        end
        chk("t1_no_exec", n_pulses, 0);

        // two 3-byte/2-byte instructions back to back, operands cleared between
        do_reset(1'b1);
        rom[16'hF000] = 8'h3A; rom[16'hF001] = 8'h34; rom[16'hF002] = 8'h12;
        rom[16'hF003] = 8'h3B; rom[16'hF004] = 8'h99; rom[16'hF005] = 8'h01;
        push(8'h3A, 16'h1234, 16'hF003);
        push(8'h3B, 16'h0099, 16'hF005);
        exec_lat = 2;
        mem_en   = 1'b1;
        reset    = 1'b1;
        end_prog("t2", 16'hF006, 80);

        // redirect with pc_load; pc_load without exec_done must not move pc
        do_reset(1'b0);
        rom[16'hF000] = 8'h3B; rom[16'hF001] = 8'hAA; rom[16'hF010] = 8'h01;
        push(8'h3B, 16'h00AA, 16'hF002);
        exec_lat     = 1;
        pc_load      = 1'b1;
        pc_load_addr = 16'hF010;
        mem_en       = 1'b1;
        reset        = 1'b1;
        wait_exec("t3a_exec", 30);
        @(negedge clk);
        chk("t3a_load_needs_done", {15'h0, mem_read, pc}, {16'h0, 16'hF002});
        @(negedge clk);
        chk("t3a_redirect", {15'h0, mem_read, mem_addr}, {16'h1, 16'hF010});
        end_prog("t3a", 16'hF011, 30);

        // same program, no redirect, single-cycle execute
        do_reset(1'b0);
        rom[16'hF000] = 8'h3B; rom[16'hF001] = 8'hAA; rom[16'hF002] = 8'h01;
        push(8'h3B, 16'h00AA, 16'hF002);
        exec_lat = 0;
        pc_load  = 1'b0;
        mem_en   = 1'b1;
        reset    = 1'b1;
        wait_exec("t3b_exec", 30);
        @(negedge clk);
        chk("t3b_no_redirect", {15'h0, mem_read, mem_addr}, {16'h1, 16'hF002});
        end_prog("t3b", 16'hF003, 30);

        // three wait cycles per byte
        do_reset(1'b0);
        rom[16'hF000] = 8'h3A; rom[16'hF001] = 8'h78; rom[16'hF002] = 8'h56; rom[16'hF003] = 8'h01;
        push(8'h3A, 16'h5678, 16'hF003);
        rd_wait = 3;
        mem_en  = 1'b1;
        reset   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_op_wait", {15'h0, mem_read, mem_addr, pc}, {15'h0, 1'b1, 16'hF000, 16'hF000});
        end
        @(negedge clk);
        chk("t4_op_taken", {15'h0, mem_read, pc}, {16'h0, 16'hF001});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_opr_wait", {15'h0, mem_read, mem_addr, pc}, {15'h0, 1'b1, 16'hF001, 16'hF001});
        end
        @(negedge clk);
        chk("t4_opr_taken", {16'h0, pc}, 32'h0000F002);
        end_prog("t4", 16'hF004, 100);

        // reset in the middle of operand fetch, then a clean restart
        do_reset(1'b0);
        rom[16'hF000] = 8'h3A; rom[16'hF001] = 8'h11; rom[16'hF002] = 8'h22;
        rd_wait = 3;
        mem_en  = 1'b1;
        reset   = 1'b1;
        n = 0;
        while (pc !== 16'hF002 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t5_mid_opr", {15'h0, mem_read, operands}, {16'h1, 16'h0011});
        do_reset(1'b1);
        rom[16'hF000] = 8'h3A; rom[16'hF001] = 8'h11; rom[16'hF002] = 8'h22; rom[16'hF003] = 8'h01;
        push(8'h3A, 16'h2211, 16'hF003);
        mem_en = 1'b1;
        reset  = 1'b1;
        @(negedge clk);
        chk("t5_restart", {15'h0, mem_read, mem_addr}, {16'h1, 16'hF000});
        end_prog("t5", 16'hF004, 100);

        // zero-operand timing, op_len saturation and PC wrap FFFF->0000
        do_reset(1'b0);
        rom[16'hF000] = 8'h00;
        rom[16'hFFFE] = 8'h3F; rom[16'hFFFF] = 8'hCD; rom[16'h0000] = 8'hAB; rom[16'h0001] = 8'h01;
        push(8'h00, 16'h0000, 16'hF001);
        push(8'h3F, 16'hABCD, 16'h0001);
        rd_wait      = 0;
        exec_lat     = 1;
        pc_load      = 1'b1;
        pc_load_addr = 16'hFFFE;
        mem_en       = 1'b1;
        reset        = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_no_early_exec", {31'h0, exec_start}, 32'h0);
        @(negedge clk);
        chk("t6_exec_cycle3", {31'h0, exec_start}, 32'h1);
        repeat (2) @(negedge clk);
        chk("t6_redirect", {16'h0, mem_addr}, 32'h0000FFFE);
        pc_load = 1'b0;
        @(negedge clk);
        chk("t6_wrap_mid", {16'h0, pc}, 32'h0000FFFF);
        @(negedge clk);
        end_prog("t6", 16'h0002, 60);

        // memory never answers
        do_reset(1'b0);
        reset = 1'b1;
`ifdef FETCH_TIMEOUT_EN
        repeat (14) @(negedge clk);
        chk("t7_before_timeout", {30'h0, fault, mem_read}, 32'h1);
        @(negedge clk);
        chk("t7_fault", {30'h0, fault, mem_read}, 32'h2);
        repeat (5) @(negedge clk);
        chk("t7_fault_sticky", {14'h0, fault, mem_read, pc}, {14'h0, 2'b10, 16'hF000});
`else
        repeat (40) @(negedge clk);
        chk("t7_still_waiting", {14'h0, fault, mem_read, mem_addr}, {14'h0, 2'b01, 16'hF000});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
